// File: rtl/dmem_pkg.sv
// Shared constants and types for the memory-stage responder.
// Op codes, FSM state encoding and wait-state counter width.
package dmem_pkg;

   localparam logic [4:0] ALUOP_LW = 5'b10100;
   localparam logic [4:0] ALUOP_SW = 5'b10101;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous word memory with registered, write-first read data.
// The array has no reset; contents survive core reset.
module dmem_sram #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
         rdata_q       <= wdata_i;
      end else begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: word loads/stores on an internal memory with
// programmable wait states, stalling the core until the access completes.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ALUop_i,
   input  logic [31:0] MemAddr_i,
   input  logic [31:0] StoreData_i,
   input  logic [31:0] WriteData_i,
   input  logic [4:0]  WriteDataNum_i,
   input  logic        WriteReg_i,
   output logic        WriteReg_o,
   output logic [4:0]  WriteDataNum_o,
   output logic [31:0] WriteData_o,
   output logic        Stall_o,
   output logic        Misaligned_o
);

   dmem_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              is_sw_q, is_sw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       sdata_q, sdata_d;
   logic [31:0]       result_q, result_d;
   logic [4:0]        rd_q, rd_d;

   logic              is_mem;
   logic              aligned;
   logic              req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rdata;
   logic              unused_addr_hi;

   assign is_mem         = (ALUop_i == ALUOP_LW) || (ALUop_i == ALUOP_SW);
   assign aligned        = (MemAddr_i[1:0] == 2'b00);
   assign req            = is_mem && aligned && !rst;
   // Upper address bits are dropped so accesses wrap modulo the memory depth.
   assign unused_addr_hi = ^MemAddr_i[31:ADDR_W+2];

   assign mem_we   = (state_q == StAccess) && (cnt_q == '0) && is_sw_q && !rst;
   // Address the array from the inputs in IDLE so read data is ready in the first ACCESS cycle.
   assign mem_addr = (state_q == StIdle) ? MemAddr_i[ADDR_W+1:2] : addr_q;

   dmem_sram #(
      .ADDR_W (ADDR_W)
   ) u_sram (
      .clk     (clk),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (sdata_q),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_sw_d  = is_sw_q;
      addr_d   = addr_q;
      sdata_d  = sdata_q;
      result_d = result_q;
      rd_d     = rd_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               state_d = StAccess;
               cnt_d   = CNT_W'(WAIT_STATES);
               is_sw_d = (ALUop_i == ALUOP_SW);
               addr_d  = MemAddr_i[ADDR_W+1:2];
               sdata_d = StoreData_i;
               rd_d    = WriteDataNum_i;
            end
         end
         StAccess: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = StDone;
               if (!is_sw_q) begin
                  result_d = mem_rdata;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         is_sw_q  <= 1'b0;
         addr_q   <= '0;
         sdata_q  <= '0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_sw_q  <= is_sw_d;
         addr_q   <= addr_d;
         sdata_q  <= sdata_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

   always_comb begin
      WriteReg_o     = 1'b0;
      WriteDataNum_o = '0;
      WriteData_o    = '0;
      Stall_o        = 1'b0;
      Misaligned_o   = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StIdle: begin
               WriteDataNum_o = WriteDataNum_i;
               WriteData_o    = WriteData_i;
               if (is_mem) begin
                  Misaligned_o = !aligned;
                  Stall_o      = aligned;
               end else begin
                  WriteReg_o = WriteReg_i;
               end
            end
            StAccess: begin
               Stall_o        = 1'b1;
               WriteDataNum_o = rd_q;
            end
            StDone: begin
               WriteReg_o     = !is_sw_q;
               WriteDataNum_o = rd_q;
               WriteData_o    = is_sw_q ? 32'h0 : result_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked against
// a word-array memory model and fixed vectors.
module tb_dmem_responder;

   localparam logic [4:0] LW  = 5'b10100;
   localparam logic [4:0] SW  = 5'b10101;
   localparam logic [4:0] NOP = 5'b01101;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        wreg;
      logic        exp_wreg;
      logic [4:0]  exp_num;
      logic [31:0] exp_data;
      logic        exp_stall;
      logic        exp_mis;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  op    [2];
   logic [31:0] ma    [2];
   logic [31:0] sd    [2];
   logic [31:0] wd    [2];
   logic [4:0]  rdn   [2];
   logic        wr    [2];
   logic        wr_o  [2];
   logic [4:0]  num_o [2];
   logic [31:0] dat_o [2];
   logic        st_o  [2];
   logic        mis_o [2];

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] mem_m [2][1024];
   vec_t        vecs  [7];

   always #5 clk = ~clk;

   dmem_responder #(
      .ADDR_W      (10),
      .WAIT_STATES (2)
   ) dut_ws2 (
      .clk            (clk),
      .rst            (rst),
      .ALUop_i        (op[0]),
      .MemAddr_i      (ma[0]),
      .StoreData_i    (sd[0]),
      .WriteData_i    (wd[0]),
      .WriteDataNum_i (rdn[0]),
      .WriteReg_i     (wr[0]),
      .WriteReg_o     (wr_o[0]),
      .WriteDataNum_o (num_o[0]),
      .WriteData_o    (dat_o[0]),
      .Stall_o        (st_o[0]),
      .Misaligned_o   (mis_o[0])
   );

   dmem_responder #(
      .ADDR_W      (10),
      .WAIT_STATES (0)
   ) dut_ws0 (
      .clk            (clk),
      .rst            (rst),
      .ALUop_i        (op[1]),
      .MemAddr_i      (ma[1]),
      .StoreData_i    (sd[1]),
      .WriteData_i    (wd[1]),
      .WriteDataNum_i (rdn[1]),
      .WriteReg_i     (wr[1]),
      .WriteReg_o     (wr_o[1]),
      .WriteDataNum_o (num_o[1]),
      .WriteData_o    (dat_o[1]),
      .Stall_o        (st_o[1]),
      .Misaligned_o   (mis_o[1])
   );

   function automatic int ws_of(input int u);
      return (u == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop(input int u);
      op[u]  = NOP;
      ma[u]  = 32'h0;
      sd[u]  = 32'h0;
      wd[u]  = 32'h0;
      rdn[u] = 5'd0;
      wr[u]  = 1'b0;
   endtask

   task automatic chk_zero(input int u, input string tag);
      chk({tag, "_wreg"}, wr_o[u], 0);
      chk({tag, "_num"}, num_o[u], 0);
      chk({tag, "_data"}, dat_o[u], 0);
      chk({tag, "_stall"}, st_o[u], 0);
      chk({tag, "_mis"}, mis_o[u], 0);
   endtask

   // Single IDLE cycle: passthrough or misaligned; must not leave IDLE.
   task automatic idle_vec(input int u, input vec_t v, input string tag);
      op[u]  = v.op;
      ma[u]  = v.addr;
      wd[u]  = v.wdata;
      rdn[u] = v.rd;
      wr[u]  = v.wreg;
      sd[u]  = $urandom;
      #1;
      chk({tag, "_wreg"}, wr_o[u], v.exp_wreg);
      chk({tag, "_stall"}, st_o[u], v.exp_stall);
      chk({tag, "_mis"}, mis_o[u], v.exp_mis);
      if (!v.exp_mis) begin
         chk({tag, "_num"}, num_o[u], v.exp_num);
         chk({tag, "_data"}, dat_o[u], v.exp_data);
      end
      step();
      chk({tag, "_stay_idle"}, st_o[u], 0);
   endtask

   // Full lw/sw transaction; inputs are scrambled during ACCESS and the
   // original request is shown again in DONE.
   task automatic mem_op(input int u, input bit is_sw, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd, input string tag);
      int          n;
      logic [9:0]  word;
      logic [31:0] exp;
      word   = addr[11:2];
      exp    = mem_m[u][word];
      op[u]  = is_sw ? SW : LW;
      ma[u]  = addr;
      sd[u]  = sdata;
      wd[u]  = $urandom;
      rdn[u] = rd;
      wr[u]  = 1'b1;
      #1;
      chk({tag, "_req_stall"}, st_o[u], 1);
      chk({tag, "_req_wreg"}, wr_o[u], 0);
      n = 0;
      while (st_o[u] === 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         op[u]  = 5'($urandom);
         ma[u]  = $urandom;
         sd[u]  = $urandom;
         wd[u]  = $urandom;
         rdn[u] = 5'($urandom);
         wr[u]  = 1'($urandom);
         #1;
         if (st_o[u] === 1'b1) chk({tag, "_access_wreg"}, wr_o[u], 0);
      end
      chk({tag, "_stall_cycles"}, n, ws_of(u) + 2);
      op[u]  = is_sw ? SW : LW;
      ma[u]  = addr;
      sd[u]  = sdata;
      rdn[u] = rd;
      wr[u]  = 1'b1;
      #1;
      chk({tag, "_done_stall"}, st_o[u], 0);
      chk({tag, "_done_mis"}, mis_o[u], 0);
      chk({tag, "_done_wreg"}, wr_o[u], !is_sw);
      if (is_sw) begin
         chk({tag, "_done_data"}, dat_o[u], 0);
         mem_m[u][word] = sdata;
      end else begin
         chk({tag, "_done_num"}, num_o[u], rd);
         chk({tag, "_done_data"}, dat_o[u], exp);
      end
      step();
      set_nop(u);
      #1;
      chk({tag, "_back_idle"}, st_o[u], 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        rv;
      logic [31:0] a;
      logic [4:0]  rop;
      int          r;

      vecs[0] = '{NOP,      32'h0,  32'h0000_0007, 5'd5,  1'b1, 1'b1, 5'd5,  32'h0000_0007, 1'b0, 1'b0};
      vecs[1] = '{5'b00000, 32'h8,  32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[2] = '{5'b10110, 32'h3,  32'h1234_ABCD, 5'd1,  1'b1, 1'b1, 5'd1,  32'h1234_ABCD, 1'b0, 1'b0};
      vecs[3] = '{LW,       32'h13, 32'h5555_0000, 5'd9,  1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1};
      vecs[4] = '{SW,       32'h2,  32'h0,         5'd2,  1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1};
      vecs[5] = '{LW,       32'h1,  32'hCAFE_F00D, 5'd4,  1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1};
      vecs[6] = '{5'b11111, 32'h0,  32'h8000_0001, 5'd17, 1'b1, 1'b1, 5'd17, 32'h8000_0001, 1'b0, 1'b0};

      // Reset: request on one unit, passthrough on the other, outputs all zero.
      op[0] = LW;  ma[0] = 32'h10; sd[0] = 32'h1; wd[0] = 32'h55; rdn[0] = 5'd3; wr[0] = 1'b1;
      op[1] = NOP; ma[1] = 32'h0;  sd[1] = 32'h2; wd[1] = 32'h7;  rdn[1] = 5'd5; wr[1] = 1'b1;
      #12;
      chk_zero(0, "rst_u0");
      chk_zero(1, "rst_u1");
      step();
      set_nop(0);
      set_nop(1);
      rst = 1'b0;
      #1;

      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 7; i++) idle_vec(u, vecs[i], $sformatf("u%0d_vec%0d", u, i));
      end
      set_nop(0);
      set_nop(1);

      // Store then load, wrap, misaligned leaves memory alone.
      mem_op(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0, "sw10");
      mem_op(0, 1'b0, 32'h10, 32'h0, 5'd3, "lw10");
      chk("lw10_const", dat_o[0], 32'h0);
      mem_op(0, 1'b1, 32'h0, 32'h0, 5'd0, "sw0_pre");
      mem_op(0, 1'b1, 32'h0000_1000, 32'h1234, 5'd0, "sw_wrap");
      mem_op(0, 1'b0, 32'h0, 32'h0, 5'd4, "lw_wrap");
      idle_vec(0, vecs[3], "mis_again");
      mem_op(0, 1'b0, 32'h10, 32'h0, 5'd0, "lw10_rd0");

      // Reset during the first ACCESS cycle of a store.
      mem_op(0, 1'b1, 32'h20, 32'h0, 5'd0, "sw20_pre");
      op[0] = SW; ma[0] = 32'h20; sd[0] = 32'hAAAA_5555; wd[0] = 32'h9; rdn[0] = 5'd6; wr[0] = 1'b1;
      #1;
      chk("rstmid_accept", st_o[0], 1);
      step();
      rst = 1'b1;
      #1;
      chk_zero(0, "rstmid");
      step();
      set_nop(0);
      rst = 1'b0;
      #1;
      chk("rstmid_released", st_o[0], 0);
      step();
      chk("rstmid_idle", st_o[0], 0);
      mem_op(0, 1'b0, 32'h20, 32'h0, 5'd2, "lw20_after_rst");

      // Zero wait states, back-to-back loads.
      mem_op(1, 1'b1, 32'h40, 32'h0BAD_F00D, 5'd0, "ws0_sw40");
      mem_op(1, 1'b1, 32'h44, 32'h1357_9BDF, 5'd0, "ws0_sw44");
      mem_op(1, 1'b0, 32'h40, 32'h0, 5'd7, "ws0_lw40");
      mem_op(1, 1'b0, 32'h44, 32'h0, 5'd8, "ws0_lw44");

      // Random mix over a small preloaded window, with random wrap bits.
      for (int u = 0; u < 2; u++) begin
         for (int w = 0; w < 8; w++) mem_op(u, 1'b1, 32'(w * 4), $urandom, 5'd0, "rnd_pre");
         for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 3);
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2);
            case (r)
               0: begin
                  rop = 5'($urandom);
                  if (rop == LW || rop == SW) rop = NOP;
                  rv = '{rop, $urandom, $urandom, 5'($urandom), 1'($urandom),
                         1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
                  rv.exp_wreg = rv.wreg;
                  rv.exp_num  = rv.rd;
                  rv.exp_data = rv.wdata;
                  idle_vec(u, rv, $sformatf("rnd%0d_%0d_pass", u, k));
               end
               1: begin
                  a[1:0] = 2'($urandom_range(1, 3));
                  rv = '{($urandom & 1) ? SW : LW, a, $urandom, 5'($urandom), 1'b1,
                         1'b0, 5'd0, 32'h0, 1'b0, 1'b1};
                  idle_vec(u, rv, $sformatf("rnd%0d_%0d_mis", u, k));
               end
               2: mem_op(u, 1'b0, a, 32'h0, 5'($urandom), $sformatf("rnd%0d_%0d_lw", u, k));
               default: mem_op(u, 1'b1, a, $urandom, 5'd0, $sformatf("rnd%0d_%0d_sw", u, k));
            endcase
         end
         set_nop(u);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-stage responder for the single-cycle RV32I core. It consumes the load/store requests the execute stage issues: ALU op code, effective address, store data and the writeback tuple.
- Performs word accesses on an internal data memory with a programmable number of wait states, and stalls the core until the access finishes.
- Non-memory ops pass straight through to writeback. Loads replace the writeback data with the memory word.
- Sits between the execute stage and the register-file writeback.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W 32-bit words.
- WAIT_STATES, 2, extra access cycles per memory op (0..15).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ALUop_i  in  5  op code from execute; 5'b10100 = lw, 5'b10101 = sw, others = non-memory
- MemAddr_i  in  32  effective byte address
- StoreData_i  in  32  sw data (rs2)
- WriteData_i  in  32  ALU/link result from execute
- WriteDataNum_i  in  5  destination register
- WriteReg_i  in  1  register write enable from execute
- WriteReg_o  out  1  register write enable to writeback
- WriteDataNum_o  out  5  destination register to writeback
- WriteData_o  out  32  writeback data
- Stall_o  out  1  high = upstream holds all inputs stable next cycle
- Misaligned_o  out  1  lw/sw with MemAddr_i[1:0] != 0 (request dropped)

Behaviour:
- Reset: all outputs are 0 while rst=1. FSM goes to IDLE and the counter clears. Memory contents are not cleared.
- FSM states: IDLE, ACCESS, DONE.
- Request: ALUop_i is lw or sw, rst=0, MemAddr_i[1:0]==0.
- IDLE, no request:
  - Outputs combinationally forward WriteReg_i, WriteDataNum_i, WriteData_i.
  - Stall_o=0.
- IDLE, misaligned lw/sw:
  - Misaligned_o=1 and WriteReg_o=0. No access, Stall_o=0, stays IDLE.
  - Misaligned_o is 0 in every other case.
- IDLE, request:
  - Stall_o=1 and WriteReg_o=0.
  - At the clock edge: latch op, word index MemAddr_i[ADDR_W+1:2], store data and WriteDataNum_i. Load counter with WAIT_STATES. Go to ACCESS.
- Address wrap: address bits above ADDR_W+1 are ignored, so accesses wrap modulo the memory depth.
- ACCESS:
  - Stall_o=1 and WriteReg_o=0.
  - If counter != 0, decrement.
  - If counter == 0: sw writes memory; lw captures the read word into a result register; go to DONE.
  - Only latched values are used in ACCESS. Input changes are ignored.
- DONE (exactly one cycle):
  - Stall_o=0.
  - lw: WriteReg_o=1, WriteDataNum_o = latched rd, WriteData_o = loaded word.
  - lw with rd==0: WriteReg_o still 1 (register file discards x0).
  - sw: WriteReg_o=0, WriteData_o=0.
  - Next state is always IDLE. The request still visible on the inputs in DONE is never re-accepted, because upstream advances at this edge.
- Latency:
  - lw/sw holds Stall_o high for WAIT_STATES+2 cycles.
  - Result appears in the following (DONE) cycle.
  - WAIT_STATES=0 gives 2 stall cycles.
- Back-to-back requests: a second request can be accepted in the cycle after DONE (IDLE).
- Read-after-write: an sw followed by an lw to the same word returns the new data.
- Reset mid-ACCESS:
  - Abort and return to IDLE with Stall_o=0.
  - A pending sw that has not reached counter==0 must not write memory.

Decomposition:
- Package dmem_pkg holds:
  - ALUOP_LW=5'b10100, ALUOP_SW=5'b10101
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2)
  - counter width constant (4)
- One sub-module, dmem_sram: a single-port synchronous 2**ADDR_W x 32 array.
  - Inputs: we, addr, wdata. Output: registered rdata.
  - Write-first behaviour.
  - No reset on the array.

Test Plan:
- Passthrough: ALUop_i=5'b01101, WriteData_i=32'h0000_0007, WriteDataNum_i=5, WriteReg_i=1 -> same cycle: WriteData_o=7, WriteDataNum_o=5, WriteReg_o=1, Stall_o=0.
- Store then load, WAIT_STATES=2:
  - Stimulus: sw addr 32'h10, data 32'hDEADBEEF; then lw addr 32'h10, rd=3.
  - Required: Stall_o high 4 cycles for each op. DONE of the lw shows WriteReg_o=1, WriteDataNum_o=3, WriteData_o=32'hDEADBEEF.
- Wrap: sw to 32'h0000_1000 (ADDR_W=10) with data 32'h1234 -> lw from 32'h0 returns 32'h1234.
- Misaligned: lw addr 32'h13 -> Misaligned_o=1, Stall_o=0, WriteReg_o=0, FSM stays IDLE; memory unchanged.
- Reset mid-store: sw 32'h20 data 32'hAAAA_5555, rst asserted in the first ACCESS cycle -> all outputs 0, Stall_o=0; a later lw 32'h20 returns the prior contents (32'h0 if never written after preload by sw 32'h0).
- WAIT_STATES=0, back-to-back lw, lw -> each stalls exactly 2 cycles and has one DONE cycle. The second is accepted in the cycle after the first DONE.
